// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and constants for the GEMM result accumulator
package gemm_pkg;

  // Width of each signed product sum delivered by the vector multiplier
  localparam int PROD_W = 24;

  // Tile state: collect K beats, then hand out the three lanes
  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Lane indices as presented on out_lane
  localparam logic [1:0] LANE_P = 2'd0;
  localparam logic [1:0] LANE_Q = 2'd1;
  localparam logic [1:0] LANE_R = 2'd2;

endpackage

// File: rtl/gemm_lane_acc.sv
// rtl/gemm_lane_acc.sv - one sign-extending wrap-around accumulator with clear
module gemm_lane_acc
  import gemm_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     add_en,
  input  logic signed [PROD_W-1:0] din,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] din_ext;

  // Signed cast widens with the sign bit; also legal when ACC_W == PROD_W
  assign din_ext = ACC_W'(din);

  // Clear wins over add; the sum wraps in two's complement
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + din_ext;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/gemm_result_accum.sv
// rtl/gemm_result_accum.sv - accumulates K p/q/r triples per tile and drains three lanes
module gemm_result_accum
  import gemm_pkg::*;
#(
  parameter int K     = 32,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] p,
  input  logic [PROD_W-1:0] q,
  input  logic [PROD_W-1:0] r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [1:0]        out_lane,
  output logic              tile_done
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic             tile_done_q, tile_done_d;

  logic xfer;
  logic out_hs;
  logic last_hs;
  logic acc_add;
  logic acc_clr;
  logic signed [ACC_W-1:0] acc_p, acc_q_lane, acc_r;

  assign xfer    = in_valid && (state_q == ACCUM);
  assign out_hs  = out_ready && (state_q == DRAIN);
  assign last_hs = out_hs && (lane_q == LANE_R);

  // clr suppresses the add and zeroes the lanes; so does finishing a drain
  assign acc_add = xfer && !clr;
  assign acc_clr = clr || last_hs;

  gemm_lane_acc #(.ACC_W(ACC_W)) u_acc_p (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .add_en(acc_add), .din(p), .acc(acc_p)
  );
  gemm_lane_acc #(.ACC_W(ACC_W)) u_acc_q (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .add_en(acc_add), .din(q), .acc(acc_q_lane)
  );
  gemm_lane_acc #(.ACC_W(ACC_W)) u_acc_r (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .add_en(acc_add), .din(r), .acc(acc_r)
  );

  // Next-state logic: clr overrides, otherwise count beats or step lanes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    tile_done_d = 1'b0;
    if (clr) begin
      state_d = ACCUM;
      cnt_d   = '0;
      lane_d  = LANE_P;
    end else begin
      case (state_q)
        ACCUM: begin
          if (xfer) begin
            if (cnt_q == CNT_LAST) begin
              state_d = DRAIN;
              lane_d  = LANE_P;
            end else begin
              cnt_d = CNT_W'(cnt_q + 1'b1);
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (lane_q == LANE_R) begin
              state_d     = ACCUM;
              cnt_d       = '0;
              lane_d      = LANE_P;
              tile_done_d = 1'b1;
            end else begin
              lane_d = lane_q + 2'd1;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Control registers, all in one process
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      lane_q      <= LANE_P;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Select the lane being presented; index 3 is unreachable
  always_comb begin
    case (lane_q)
      LANE_Q:  out_data = acc_q_lane;
      LANE_R:  out_data = acc_r;
      default: out_data = acc_p;
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign out_lane  = lane_q;
  assign tile_done = tile_done_q;

endmodule
